fpro_bus_arbiter: RTL

//  Shares the single FPro MMIO bus between NUM_MASTERS requesters, e.g. the MicroBlaze bridge and a DMA engine.

---
 rtl/fpro_bus_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/fpro_bus_arbiter.sv
// Round-robin arbiter sharing one FPro MMIO bus among NUM_MASTERS single-beat requesters.
// Each grant runs ACCESS (one strobe cycle) then RESP (one ack cycle) before the next grant.
//
//  state  | meaning
//  IDLE   | waiting for any m_req; grants on the edge a request is seen
//  ACCESS | mmio strobe cycle driven from the latched command
//  RESP   | m_ack pulse to the granted master, read data presented

module fpro_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 21,
    parameter int DATA_WIDTH  = 32,
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_rd_data,
    output logic                              mmio_cs,
    output logic                              mmio_wr,
    output logic                              mmio_read,
    output logic [ADDR_WIDTH-1:0]             mmio_addr,
    output logic [DATA_WIDTH-1:0]             mmio_wr_data,
    input  logic [DATA_WIDTH-1:0]             mmio_rd_data,
    output logic [IW-1:0]                     grant_id,
    output logic                              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic          found;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_ptr;
    int            idx;

    // First requester at or after the pointer, wrapping modulo NUM_MASTERS.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && m_req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
        if (int'(winner) == NUM_MASTERS - 1)
            next_ptr = '0;
        else
            next_ptr = winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            m_ack        <= '0;
            m_rd_data    <= '0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_read    <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
        end else begin
            m_ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        mmio_addr    <= m_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        mmio_wr_data <= m_wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        mmio_wr      <= m_wr[winner];
                        mmio_read    <= ~m_wr[winner];
                        mmio_cs      <= 1'b1;
                        grant_id     <= winner;
                        ptr          <= next_ptr;
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mmio_cs         <= 1'b0;
                    mmio_wr         <= 1'b0;
                    mmio_read       <= 1'b0;
                    m_rd_data       <= mmio_rd_data;
                    m_ack[grant_id] <= 1'b1;
                    state           <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mmio_cs   <= 1'b0;
                    mmio_wr   <= 1'b0;
                    mmio_read <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
